game_flow_ctrl: RTL and testbench
=================================

Name: game_flow_ctrl

Overview:
- Top-level screen sequencer for Pong Toss.
- Walks the game through four states: start screen, 3-2-1 countdown, play, game over.
- Debounces the start button and tracks score, lives and high score.
- Registers the final VGA colour by muxing the per-screen renderers. The start-screen renderer feeds its start_* inputs; the play and game-over renderers feed the others.

Parameters:
- DEBOUNCE_FRAMES, 3: consecutive frame_tick samples a synchronized button level must hold before it is accepted.
- COUNT_STEP_FRAMES, 60: frame_ticks per countdown digit.
- OVER_HOLD_FRAMES, 120: frame_ticks the game-over screen ignores the button.
- START_LIVES, 3: lives loaded at game start; legal range 1..3.
- SCORE_W, 8: score and high-score width.

Ports:
- clk_d  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- btn_start  in  1  raw push button, asynchronous to clk_d
- frame_tick  in  1  one-cycle pulse once per frame at vblank start
- cup_hit  in  1  one-cycle pulse: ball landed in a cup
- ball_miss  in  1  one-cycle pulse: ball missed
- video_on  in  1  visible-region flag from the VGA timing block
- start_r/start_g/start_b  in  4 each  start-screen colour
- play_r/play_g/play_b  in  4 each  gameplay colour
- over_r/over_g/over_b  in  4 each  game-over colour
- red/green/blue  out  4 each  registered VGA colour
- state  out  2  0=IDLE, 1=COUNTDOWN, 2=PLAY, 3=OVER
- game_active  out  1  high only in PLAY
- countdown_val  out  2  current digit 3/2/1 during COUNTDOWN, else 0
- score  out  SCORE_W  current score
- lives  out  2  remaining lives
- high_score  out  SCORE_W  best score since reset

Behaviour:

Reset:
- Asserting rst clears immediately to state=IDLE.
- All counters, score, high_score, countdown_val and red/green/blue go to 0.
- lives=START_LIVES; synchronizer and debounced level go to 0.
- Reset mid-game behaves the same; no state survives it.

Button path:
- 2-FF synchronizer on btn_start.
- On each frame_tick, compare the synchronized level with the debounced level. If they differ, increment the stable counter; if they match, clear it.
- When the stable counter reaches DEBOUNCE_FRAMES, the debounced level takes the synchronized value and the counter clears.
- press is a one-cycle internal pulse on the debounced rising edge. A release never generates press.

FSM (all transitions on clk_d):
- IDLE -> COUNTDOWN on press.
  - Entry actions: load countdown_val=3, clear the frame counter, score=0, lives=START_LIVES.
- COUNTDOWN: the frame counter increments on frame_tick.
  - When it reaches COUNT_STEP_FRAMES it clears and countdown_val decrements.
  - A decrement from 1 goes to PLAY with countdown_val=0.
  - press is ignored.
- PLAY:
  - cup_hit: score += 1, saturating at all-ones.
  - ball_miss: lives -= 1.
  - A miss while lives==1 goes to OVER with lives=0.
  - cup_hit and ball_miss in the same cycle: the hit is counted and the miss is dropped.
  - press is ignored.
- OVER:
  - On entry: the hold counter clears, and high_score takes score if score > high_score (comparison uses the final score, visible one cycle after entry).
  - The hold counter increments on frame_tick and saturates at OVER_HOLD_FRAMES.
  - press with hold counter == OVER_HOLD_FRAMES goes to IDLE. press before that is discarded (not queued).
- cup_hit and ball_miss outside PLAY are ignored.

Colour output:
- Registered with 1-cycle latency from the inputs.
- video_on=0 forces 0/0/0.
- Source by state, using the registered state of the same cycle: IDLE=start, COUNTDOWN=play, PLAY=play, OVER=over.
- A state change takes effect on the first pixel after the transition (mid-frame switch allowed).

Test Plan:
Bench parameters unless noted: DEBOUNCE_FRAMES=2, COUNT_STEP_FRAMES=4, OVER_HOLD_FRAMES=5, START_LIVES=3; frame_tick every 10 clk_d.
1. Bounce: btn_start high for 1 frame_tick period, then low -> state stays 0. Held high for 3 ticks -> state=1 with countdown_val=3 within 2 ticks of stability plus 3 clk_d.
2. Countdown: after entry, countdown_val reads 3,2,1 with 4 ticks each. On the 12th tick, state=2, game_active=1, countdown_val=0.
3. Scoring: 5 cup_hit pulses -> score=5. cup_hit and ball_miss in the same cycle -> score=6, lives=3. SCORE_W=3 with 9 hits -> score=7.
4. Game over: 3 ball_miss pulses -> lives 2,1,0 and state=3. With high_score=0 and score=6, high_score=6 one cycle later. A later game scoring 4 leaves high_score=6.
5. Hold: press 2 ticks into OVER -> stays 3. Press after 5 ticks -> state=0, and score/lives are not reloaded until the next press.
6. Mux and reset: video_on=0 -> red/green/blue=0. In IDLE, start inputs 0xF/0x0/0x0 appear 1 cycle later. rst asserted mid-PLAY -> outputs clear immediately with state=0, lives=3, high_score=0.

Source files
------------

// File: rtl/game_flow_ctrl.sv
// rtl/game_flow_ctrl.sv - Pong Toss screen sequencer: button debounce, countdown, scoring and VGA colour mux
module game_flow_ctrl #(
    parameter int DEBOUNCE_FRAMES   = 3,
    parameter int COUNT_STEP_FRAMES = 60,
    parameter int OVER_HOLD_FRAMES  = 120,
    parameter int START_LIVES       = 3,
    parameter int SCORE_W           = 8
) (
    input  logic               clk_d,
    input  logic               rst,
    input  logic               btn_start,
    input  logic               frame_tick,
    input  logic               cup_hit,
    input  logic               ball_miss,
    input  logic               video_on,
    input  logic [3:0]         start_r,
    input  logic [3:0]         start_g,
    input  logic [3:0]         start_b,
    input  logic [3:0]         play_r,
    input  logic [3:0]         play_g,
    input  logic [3:0]         play_b,
    input  logic [3:0]         over_r,
    input  logic [3:0]         over_g,
    input  logic [3:0]         over_b,
    output logic [3:0]         red,
    output logic [3:0]         green,
    output logic [3:0]         blue,
    output logic [1:0]         state,
    output logic               game_active,
    output logic [1:0]         countdown_val,
    output logic [SCORE_W-1:0] score,
    output logic [1:0]         lives,
    output logic [SCORE_W-1:0] high_score
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_PLAY  = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    // One frame counter serves both the countdown step and the game-over hold.
    localparam int CNT_MAX = (COUNT_STEP_FRAMES > OVER_HOLD_FRAMES) ? COUNT_STEP_FRAMES : OVER_HOLD_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int DB_W    = $clog2(DEBOUNCE_FRAMES + 1);

    logic            sync1_q, sync2_q;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            db_level_q, db_level_d;
    logic            db_prev_q;
    logic            press;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         cd_q, cd_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] high_q, high_d;
    logic [1:0]         lives_q, lives_d;
    logic [3:0]         red_q, green_q, blue_q;
    logic [3:0]         red_d, green_d, blue_d;

    always_ff @(posedge clk_d or posedge rst) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            db_cnt_q   <= '0;
            db_level_q <= 1'b0;
            db_prev_q  <= 1'b0;
        end else begin
            sync1_q    <= btn_start;
            sync2_q    <= sync1_q;
            db_cnt_q   <= db_cnt_d;
            db_level_q <= db_level_d;
            db_prev_q  <= db_level_q;
        end
    end

    always_comb begin
        db_cnt_d   = db_cnt_q;
        db_level_d = db_level_q;
        if (frame_tick) begin
            if (sync2_q != db_level_q) begin
                if (db_cnt_q == DB_W'(DEBOUNCE_FRAMES - 1)) begin
                    db_level_d = sync2_q;
                    db_cnt_d   = '0;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end else begin
                db_cnt_d = '0;
            end
        end
    end

    assign press = db_level_q & ~db_prev_q;

    always_ff @(posedge clk_d or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            cd_q    <= 2'd0;
            score_q <= '0;
            high_q  <= '0;
            lives_q <= 2'(START_LIVES);
            red_q   <= 4'd0;
            green_q <= 4'd0;
            blue_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cd_q    <= cd_d;
            score_q <= score_d;
            high_q  <= high_d;
            lives_q <= lives_d;
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cd_d    = cd_q;
        score_d = score_q;
        high_d  = high_q;
        lives_d = lives_q;
        case (state_q)
            S_IDLE: begin
                if (press) begin
                    state_d = S_COUNT;
                    cd_d    = 2'd3;
                    cnt_d   = '0;
                    score_d = '0;
                    lives_d = 2'(START_LIVES);
                end
            end
            S_COUNT: begin
                if (frame_tick) begin
                    if (cnt_q == CNT_W'(COUNT_STEP_FRAMES - 1)) begin
                        cnt_d = '0;
                        if (cd_q == 2'd1) begin
                            state_d = S_PLAY;
                            cd_d    = 2'd0;
                        end else begin
                            cd_d = cd_q - 2'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_PLAY: begin
                // A simultaneous hit wins; the miss in that cycle is dropped.
                if (cup_hit) begin
                    if (score_q != '1) begin
                        score_d = score_q + SCORE_W'(1);
                    end
                end else if (ball_miss) begin
                    if (lives_q <= 2'd1) begin
                        state_d = S_OVER;
                        lives_d = 2'd0;
                        cnt_d   = '0;
                    end else begin
                        lives_d = lives_q - 2'd1;
                    end
                end
            end
            S_OVER: begin
                if (score_q > high_q) begin
                    high_d = score_q;
                end
                if (frame_tick && (cnt_q != CNT_W'(OVER_HOLD_FRAMES))) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (press && (cnt_q == CNT_W'(OVER_HOLD_FRAMES))) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        red_d   = 4'd0;
        green_d = 4'd0;
        blue_d  = 4'd0;
        if (video_on) begin
            case (state_q)
                S_IDLE: begin
                    red_d   = start_r;
                    green_d = start_g;
                    blue_d  = start_b;
                end
                S_OVER: begin
                    red_d   = over_r;
                    green_d = over_g;
                    blue_d  = over_b;
                end
                default: begin
                    red_d   = play_r;
                    green_d = play_g;
                    blue_d  = play_b;
                end
            endcase
        end
    end

    assign red           = red_q;
    assign green         = green_q;
    assign blue          = blue_q;
    assign state         = state_q;
    assign game_active   = (state_q == S_PLAY);
    assign countdown_val = cd_q;
    assign score         = score_q;
    assign lives         = lives_q;
    assign high_score    = high_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb/tb_game_flow_ctrl.sv - directed bench for game_flow_ctrl
module tb_game_flow_ctrl;

    logic       clk_d = 1'b0;
    logic       rst = 1'b1;
    logic       btn_start = 1'b0;
    logic       frame_tick = 1'b0;
    logic       cup_hit = 1'b0;
    logic       extra_hit = 1'b0;
    logic       ball_miss = 1'b0;
    logic       video_on = 1'b0;
    logic [3:0] start_r = 4'd0, start_g = 4'd0, start_b = 4'd0;
    logic [3:0] play_r = 4'd0, play_g = 4'd0, play_b = 4'd0;
    logic [3:0] over_r = 4'd0, over_g = 4'd0, over_b = 4'd0;

    logic [3:0] red, green, blue;
    logic [1:0] state, countdown_val, lives;
    logic       game_active;
    logic [7:0] score, high_score;

    logic [3:0] s_red, s_green, s_blue;
    logic [1:0] s_state, s_countdown_val, s_lives;
    logic       s_game_active;
    logic [2:0] s_score, s_high_score;
    logic       s_cup_hit;

    int n_pass  = 0;
    int n_total = 0;

    assign s_cup_hit = cup_hit | extra_hit;

    always #5 clk_d = ~clk_d;

    game_flow_ctrl #(
        .DEBOUNCE_FRAMES(2), .COUNT_STEP_FRAMES(4), .OVER_HOLD_FRAMES(5),
        .START_LIVES(3), .SCORE_W(8)
    ) u_dut (
        .clk_d(clk_d), .rst(rst), .btn_start(btn_start), .frame_tick(frame_tick),
        .cup_hit(cup_hit), .ball_miss(ball_miss), .video_on(video_on),
        .start_r(start_r), .start_g(start_g), .start_b(start_b),
        .play_r(play_r), .play_g(play_g), .play_b(play_b),
        .over_r(over_r), .over_g(over_g), .over_b(over_b),
        .red(red), .green(green), .blue(blue), .state(state),
        .game_active(game_active), .countdown_val(countdown_val),
        .score(score), .lives(lives), .high_score(high_score)
    );

    game_flow_ctrl #(
        .DEBOUNCE_FRAMES(2), .COUNT_STEP_FRAMES(4), .OVER_HOLD_FRAMES(5),
        .START_LIVES(3), .SCORE_W(3)
    ) u_dut3 (
        .clk_d(clk_d), .rst(rst), .btn_start(btn_start), .frame_tick(frame_tick),
        .cup_hit(s_cup_hit), .ball_miss(ball_miss), .video_on(video_on),
        .start_r(start_r), .start_g(start_g), .start_b(start_b),
        .play_r(play_r), .play_g(play_g), .play_b(play_b),
        .over_r(over_r), .over_g(over_g), .over_b(over_b),
        .red(s_red), .green(s_green), .blue(s_blue), .state(s_state),
        .game_active(s_game_active), .countdown_val(s_countdown_val),
        .score(s_score), .lives(s_lives), .high_score(s_high_score)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk_d);
        #1;
    endtask

    task automatic frame();
        repeat (9) cyc();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
    endtask

    task automatic pulse_hit();
        cup_hit = 1'b1;
        cyc();
        cup_hit = 1'b0;
    endtask

    task automatic pulse_miss();
        ball_miss = 1'b1;
        cyc();
        ball_miss = 1'b0;
    endtask

    initial begin
        repeat (3) cyc();
        check("rst_state", 32'(state), 32'd0);
        check("rst_lives", 32'(lives), 32'd3);
        check("rst_score", 32'(score), 32'd0);
        check("rst_high", 32'(high_score), 32'd0);
        check("rst_cd", 32'(countdown_val), 32'd0);
        check("rst_rgb", {20'd0, red, green, blue}, 32'd0);
        rst = 1'b0;
        cyc();

        // Bounce: one tick high is not enough.
        btn_start = 1'b1;
        frame();
        btn_start = 1'b0;
        repeat (3) frame();
        check("bounce_state", 32'(state), 32'd0);

        // Stable press: accepted on the second tick.
        btn_start = 1'b1;
        repeat (2) frame();
        repeat (3) cyc();
        check("press_state", 32'(state), 32'd1);
        check("press_cd", 32'(countdown_val), 32'd3);
        btn_start = 1'b0;

        repeat (3) frame();
        check("cd_3", 32'(countdown_val), 32'd3);
        frame();
        check("cd_2", 32'(countdown_val), 32'd2);
        repeat (3) frame();
        check("cd_2b", 32'(countdown_val), 32'd2);
        frame();
        check("cd_1", 32'(countdown_val), 32'd1);
        repeat (3) frame();
        check("cd_11_state", 32'(state), 32'd1);
        frame();
        check("play_state", 32'(state), 32'd2);
        check("play_active", 32'(game_active), 32'd1);
        check("play_cd", 32'(countdown_val), 32'd0);

        // Scoring; the narrow instance also sees three extra hits.
        repeat (5) pulse_hit();
        check("score_5", 32'(score), 32'd5);
        repeat (3) begin
            extra_hit = 1'b1;
            cyc();
            extra_hit = 1'b0;
        end
        check("score_5_unchanged", 32'(score), 32'd5);
        cup_hit = 1'b1;
        ball_miss = 1'b1;
        cyc();
        cup_hit = 1'b0;
        ball_miss = 1'b0;
        check("hitmiss_score", 32'(score), 32'd6);
        check("hitmiss_lives", 32'(lives), 32'd3);
        check("sat_score_w3", 32'(s_score), 32'd7);

        // Game over.
        pulse_miss();
        check("lives_2", 32'(lives), 32'd2);
        pulse_miss();
        check("lives_1", 32'(lives), 32'd1);
        pulse_miss();
        check("lives_0", 32'(lives), 32'd0);
        check("over_state", 32'(state), 32'd3);
        check("over_active", 32'(game_active), 32'd0);
        check("high_entry", 32'(high_score), 32'd0);
        cyc();
        check("high_6", 32'(high_score), 32'd6);
        pulse_hit();
        check("over_hit_ignored", 32'(score), 32'd6);

        // Early press during hold is discarded.
        btn_start = 1'b1;
        repeat (2) frame();
        repeat (3) cyc();
        check("hold_early", 32'(state), 32'd3);
        btn_start = 1'b0;
        repeat (2) frame();
        btn_start = 1'b1;
        frame();
        check("hold_t5", 32'(state), 32'd3);
        frame();
        repeat (3) cyc();
        check("hold_release", 32'(state), 32'd0);
        check("idle_score_kept", 32'(score), 32'd6);
        check("idle_lives_kept", 32'(lives), 32'd0);

        // Second game scoring 4 must not lower high score.
        btn_start = 1'b0;
        repeat (2) frame();
        btn_start = 1'b1;
        repeat (2) frame();
        repeat (3) cyc();
        check("g2_state", 32'(state), 32'd1);
        check("g2_score", 32'(score), 32'd0);
        check("g2_lives", 32'(lives), 32'd3);
        btn_start = 1'b0;
        repeat (12) frame();
        check("g2_play", 32'(state), 32'd2);
        repeat (4) pulse_hit();
        check("g2_score4", 32'(score), 32'd4);
        repeat (3) pulse_miss();
        cyc();
        check("g2_over", 32'(state), 32'd3);
        check("g2_high", 32'(high_score), 32'd6);

        // Colour mux in OVER.
        start_r = 4'hF; start_g = 4'h0; start_b = 4'h0;
        play_r = 4'h0; play_g = 4'hA; play_b = 4'h0;
        over_r = 4'h0; over_g = 4'h0; over_b = 4'h5;
        video_on = 1'b1;
        cyc();
        check("mux_over", {20'd0, red, green, blue}, 32'h005);
        video_on = 1'b0;
        cyc();
        check("mux_blank", {20'd0, red, green, blue}, 32'h000);

        repeat (4) frame();
        btn_start = 1'b1;
        repeat (2) frame();
        repeat (3) cyc();
        check("g2_idle", 32'(state), 32'd0);
        video_on = 1'b1;
        check("mux_latency", {20'd0, red, green, blue}, 32'h000);
        cyc();
        check("mux_idle", {20'd0, red, green, blue}, 32'hF00);

        btn_start = 1'b0;
        repeat (2) frame();
        btn_start = 1'b1;
        repeat (2) frame();
        repeat (3) cyc();
        check("mux_count", {20'd0, red, green, blue}, 32'h0A0);
        btn_start = 1'b0;
        repeat (12) frame();
        repeat (2) pulse_hit();
        check("g3_play", 32'(state), 32'd2);

        // Asynchronous reset mid-PLAY.
        rst = 1'b1;
        #1;
        check("rst_mid_state", 32'(state), 32'd0);
        check("rst_mid_lives", 32'(lives), 32'd3);
        check("rst_mid_high", 32'(high_score), 32'd0);
        check("rst_mid_score", 32'(score), 32'd0);
        check("rst_mid_rgb", {20'd0, red, green, blue}, 32'h000);
        cyc();
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
